// File: rtl/pipe_rx_data_if.sv
// pipe_rx_data_if: PIPE receive bus from the PHY plus the data bus that
// leaves the receiver toward the descrambler.
//
//   Rx*            : PHY -> receiver (data, K flags, beat/lock qualifiers,
//                    block start and 2-bit sync header)
//   descrambler*   : receiver -> descrambler (registered data, K flags,
//                    valid, current block header, block start/end markers)
//
// modport master : PHY/environment side (drives Rx*, observes descrambler*)
// modport slave  : receiver side (observes Rx*, drives descrambler*)
interface pipe_rx_data_if;
  logic [31:0] RxData;
  logic [3:0]  RxDataK;
  logic        RxDataValid;
  logic        RxValid;
  logic        RxStartBlock;
  logic [1:0]  RxSyncHeader;

  logic [31:0] descramblerDataIn;
  logic [3:0]  descramblerDataK;
  logic        descramblerDataValid;
  logic [1:0]  descramblerSyncHeader;
  logic        descramblerStartBlock;
  logic        descramblerBlockEnd;

  modport master (
    output RxData, RxDataK, RxDataValid, RxValid, RxStartBlock, RxSyncHeader,
    input  descramblerDataIn, descramblerDataK, descramblerDataValid,
           descramblerSyncHeader, descramblerStartBlock, descramblerBlockEnd
  );

  modport slave (
    input  RxData, RxDataK, RxDataValid, RxValid, RxStartBlock, RxSyncHeader,
    output descramblerDataIn, descramblerDataK, descramblerDataValid,
           descramblerSyncHeader, descramblerStartBlock, descramblerBlockEnd
  );
endinterface

// File: rtl/pipe_rx_data.sv
// pipe_rx_data: PIPE receive data path toward the descrambler.
// Gen1/2 beats are width-masked and forwarded with valid = RxValid & RxDataValid.
// Gen3+ beats are framed into 128b/130b blocks: the block locks on a valid
// sync header, counts beats per block, marks block start/end and pulses
// errors on bad headers or broken framing. Every output is registered.
//
// Ports:
//   pclk            : PIPE clock, rising edge
//   reset           : synchronous, active-high
//   generation      : link generation 1..5, other values are inactive
//   bus (slave)     : Rx* inputs from the PHY, descrambler* outputs
//   syncHeaderError : one-cycle pulse, header 00 or 11 at a block start
//   blockAlignError : one-cycle pulse, block start missing or misplaced
//   blockLocked     : Gen3+ block framing acquired
module pipe_rx_data #(
  parameter int unsigned pipe_width_gen1 = 8,
  parameter int unsigned pipe_width_gen2 = 8,
  parameter int unsigned pipe_width_gen3 = 16,
  parameter int unsigned pipe_width_gen4 = 32,
  parameter int unsigned pipe_width_gen5 = 32
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic [2:0]           generation,
  pipe_rx_data_if.slave        bus,
  output logic                 syncHeaderError,
  output logic                 blockAlignError,
  output logic                 blockLocked
);

  typedef enum logic {SEEK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  hdr_q, hdr_d;
  logic [2:0]  gen_q;

  logic [31:0] data_q, data_d;
  logic [3:0]  k_q, k_d;
  logic        valid_q, valid_d;
  logic [1:0]  sync_hdr_q, sync_hdr_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic        sh_err_q, sh_err_d;
  logic        align_err_q, align_err_d;
  logic        locked_q, locked_d;

  int unsigned width;
  logic [31:0] data_mask;
  logic [3:0]  k_mask;
  logic [2:0]  last_idx;
  logic        gen_supported;
  logic        gen_low;
  logic        gen_chg;
  logic        qual;
  logic        hdr_ok;

  // Per-generation lane width and the masks / last-beat index derived from it.
  always_comb begin
    width         = 32;
    gen_supported = 1'b1;
    gen_low       = 1'b0;
    case (generation)
      3'd1: begin width = pipe_width_gen1; gen_low = 1'b1; end
      3'd2: begin width = pipe_width_gen2; gen_low = 1'b1; end
      3'd3: width = pipe_width_gen3;
      3'd4: width = pipe_width_gen4;
      3'd5: width = pipe_width_gen5;
      default: gen_supported = 1'b0;
    endcase
    data_mask = 32'hFFFF_FFFF >> (32 - width);
    k_mask    = 4'hF >> (4 - width / 8);
    // Beats per block minus one; 128/W fits 3 bits for W >= 16.
    last_idx  = 3'((128 / width) - 1);
  end

  assign gen_chg = (generation != gen_q);
  assign qual    = bus.RxValid & bus.RxDataValid;
  // Only 01 and 10 are legal 128b/130b sync headers.
  assign hdr_ok  = ^bus.RxSyncHeader;

  // Next-state and next-output logic, in priority order: unsupported
  // generation, Gen1/2 passthrough, generation change, loss of RxValid,
  // then the block framing FSM.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    hdr_d       = hdr_q;
    data_d      = bus.RxData & data_mask;
    k_d         = bus.RxDataK & k_mask;
    valid_d     = 1'b0;
    start_d     = 1'b0;
    end_d       = 1'b0;
    sh_err_d    = 1'b0;
    align_err_d = 1'b0;

    if (!gen_supported) begin
      state_d    = SEEK;
      beat_cnt_d = '0;
      hdr_d      = '0;
      data_d     = '0;
      k_d        = '0;
    end else if (gen_low) begin
      // No block framing below Gen3; keep the FSM parked.
      state_d    = SEEK;
      beat_cnt_d = '0;
      valid_d    = qual;
    end else if (gen_chg || !bus.RxValid) begin
      state_d    = SEEK;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        SEEK: begin
          if (qual && bus.RxStartBlock) begin
            if (hdr_ok) begin
              state_d    = LOCKED;
              valid_d    = 1'b1;
              start_d    = 1'b1;
              hdr_d      = bus.RxSyncHeader;
              beat_cnt_d = 3'd1;
            end else begin
              sh_err_d = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (!bus.RxDataValid) begin
            // Stall: hold count and header, emit nothing.
          end else if (beat_cnt_q == 3'd0) begin
            if (!bus.RxStartBlock) begin
              align_err_d = 1'b1;
              state_d     = SEEK;
            end else if (!hdr_ok) begin
              sh_err_d = 1'b1;
              state_d  = SEEK;
            end else begin
              valid_d    = 1'b1;
              start_d    = 1'b1;
              hdr_d      = bus.RxSyncHeader;
              beat_cnt_d = 3'd1;
            end
          end else if (bus.RxStartBlock) begin
            // Start in mid-block: drop lock; re-lock only on a later beat.
            align_err_d = 1'b1;
            state_d     = SEEK;
            beat_cnt_d  = '0;
          end else begin
            valid_d = 1'b1;
            if (beat_cnt_q == last_idx) begin
              end_d      = 1'b1;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d    = SEEK;
          beat_cnt_d = '0;
        end
      endcase
    end

    locked_d   = (state_d == LOCKED);
    sync_hdr_d = locked_d ? hdr_d : 2'b00;
  end

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= SEEK;
      beat_cnt_q  <= '0;
      hdr_q       <= '0;
      gen_q       <= '0;
      data_q      <= '0;
      k_q         <= '0;
      valid_q     <= 1'b0;
      sync_hdr_q  <= '0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      sh_err_q    <= 1'b0;
      align_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      hdr_q       <= hdr_d;
      gen_q       <= generation;
      data_q      <= data_d;
      k_q         <= k_d;
      valid_q     <= valid_d;
      sync_hdr_q  <= sync_hdr_d;
      start_q     <= start_d;
      end_q       <= end_d;
      sh_err_q    <= sh_err_d;
      align_err_q <= align_err_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.descramblerDataIn     = data_q;
  assign bus.descramblerDataK      = k_q;
  assign bus.descramblerDataValid  = valid_q;
  assign bus.descramblerSyncHeader = sync_hdr_q;
  assign bus.descramblerStartBlock = start_q;
  assign bus.descramblerBlockEnd   = end_q;
  assign syncHeaderError           = sh_err_q;
  assign blockAlignError           = align_err_q;
  assign blockLocked               = locked_q;

endmodule

// File: tb/tb_pipe_rx_data.sv
// tb_pipe_rx_data: directed bench for pipe_rx_data with hand-computed
// expectations for Gen1 passthrough, Gen3/4/5 block framing, stalls,
// header and alignment errors, generation change, RxValid loss and reset.
module tb_pipe_rx_data;

  logic       pclk;
  logic       reset;
  logic [2:0] generation;
  logic       syncHeaderError;
  logic       blockAlignError;
  logic       blockLocked;

  int checks;
  int failures;

  pipe_rx_data_if bus ();

  pipe_rx_data dut (
    .pclk            (pclk),
    .reset           (reset),
    .generation      (generation),
    .bus             (bus),
    .syncHeaderError (syncHeaderError),
    .blockAlignError (blockAlignError),
    .blockLocked     (blockLocked)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Drive one beat, clock it in, then settle 1 time unit past the edge so
  // the registered outputs for that beat can be sampled.
  task automatic applyStimulus(input logic [2:0] gen, input logic [31:0] data,
                               input logic [3:0] k, input logic dv, input logic v,
                               input logic sb, input logic [1:0] sh);
    generation       = gen;
    bus.RxData       = data;
    bus.RxDataK      = k;
    bus.RxDataValid  = dv;
    bus.RxValid      = v;
    bus.RxStartBlock = sb;
    bus.RxSyncHeader = sh;
    @(posedge pclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Framing outputs of the current beat.
  task automatic checkFrame(input string tag, input logic valid, input logic sb,
                            input logic be, input logic [1:0] sh, input logic lk,
                            input logic she, input logic bae);
    checkOutput({tag, ".valid"}, 32'(bus.descramblerDataValid), 32'(valid));
    checkOutput({tag, ".start"}, 32'(bus.descramblerStartBlock), 32'(sb));
    checkOutput({tag, ".end"},   32'(bus.descramblerBlockEnd), 32'(be));
    checkOutput({tag, ".hdr"},   32'(bus.descramblerSyncHeader), 32'(sh));
    checkOutput({tag, ".lock"},  32'(blockLocked), 32'(lk));
    checkOutput({tag, ".sherr"}, 32'(syncHeaderError), 32'(she));
    checkOutput({tag, ".alerr"}, 32'(blockAlignError), 32'(bae));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    applyStimulus(3'd1, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b0, 2'b00);
    applyStimulus(3'd1, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("rst.data", bus.descramblerDataIn, 32'h0);
    checkOutput("rst.k", 32'(bus.descramblerDataK), 32'h0);
    checkFrame("rst", 0, 0, 0, 2'b00, 0, 0, 0);
    reset = 1'b0;

    // Gen1 passthrough, 8-bit lane.
    applyStimulus(3'd1, 32'hAABB_CC5C, 4'hF, 1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("g1.data", bus.descramblerDataIn, 32'h0000_005C);
    checkOutput("g1.k", 32'(bus.descramblerDataK), 32'h1);
    checkFrame("g1", 1, 0, 0, 2'b00, 0, 0, 0);
    applyStimulus(3'd1, 32'h1122_3344, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    checkOutput("g1nq.data", bus.descramblerDataIn, 32'h0000_0044);
    checkOutput("g1nq.valid", 32'(bus.descramblerDataValid), 32'h0);

    // Gen3: first cycle at the new generation is swallowed, then one block.
    applyStimulus(3'd3, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 2'b10);
    checkFrame("g3chg", 0, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'd3, 32'hFFFF_A000 + 32'(i), 4'hF, 1'b1, 1'b1,
                    (i == 0), 2'b10);
      checkOutput($sformatf("g3b%0d.data", i), bus.descramblerDataIn,
                  32'h0000_A000 + 32'(i));
      checkFrame($sformatf("g3b%0d", i), 1, (i == 0), (i == 7), 2'b10, 1, 0, 0);
    end
    checkOutput("g3.k", 32'(bus.descramblerDataK), 32'h3);
    // Missing StartBlock right after BlockEnd.
    applyStimulus(3'd3, 32'h1234, 4'h0, 1'b1, 1'b1, 1'b0, 2'b10);
    checkFrame("g3nostart", 0, 0, 0, 2'b00, 0, 0, 1);
    // SEEK with illegal header 11, then the pulse must clear.
    applyStimulus(3'd3, 32'h1234, 4'h0, 1'b1, 1'b1, 1'b1, 2'b11);
    checkFrame("g3hdr11", 0, 0, 0, 2'b00, 0, 1, 0);
    applyStimulus(3'd3, 32'h1234, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    checkFrame("g3idle", 0, 0, 0, 2'b00, 0, 0, 0);

    // Gen4: 4 beats per block with a 2-cycle stall after beat 1.
    applyStimulus(3'd4, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    applyStimulus(3'd4, 32'hCAFE_0000, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    checkOutput("g4b0.data", bus.descramblerDataIn, 32'hCAFE_0000);
    checkFrame("g4b0", 1, 1, 0, 2'b01, 1, 0, 0);
    applyStimulus(3'd4, 32'hCAFE_0001, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    checkFrame("g4b1", 1, 0, 0, 2'b01, 1, 0, 0);
    applyStimulus(3'd4, 32'hCAFE_0002, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    checkFrame("g4stall0", 0, 0, 0, 2'b01, 1, 0, 0);
    applyStimulus(3'd4, 32'hCAFE_0002, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    checkFrame("g4stall1", 0, 0, 0, 2'b01, 1, 0, 0);
    applyStimulus(3'd4, 32'hCAFE_0002, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    checkFrame("g4b2", 1, 0, 0, 2'b01, 1, 0, 0);
    applyStimulus(3'd4, 32'hCAFE_0003, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("g4b3.data", bus.descramblerDataIn, 32'hCAFE_0003);
    checkFrame("g4b3", 1, 0, 1, 2'b01, 1, 0, 0);

    // Gen5: StartBlock at beat_cnt=2 breaks framing, next start re-locks.
    applyStimulus(3'd5, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    applyStimulus(3'd5, 32'h5000_0000, 4'h0, 1'b1, 1'b1, 1'b1, 2'b10);
    checkFrame("g5b0", 1, 1, 0, 2'b10, 1, 0, 0);
    applyStimulus(3'd5, 32'h5000_0001, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    applyStimulus(3'd5, 32'h5000_0002, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    checkFrame("g5align", 0, 0, 0, 2'b00, 0, 0, 1);
    applyStimulus(3'd5, 32'h5000_0003, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    checkFrame("g5relock", 1, 1, 0, 2'b01, 1, 0, 0);

    // Locked at Gen4, generation moves to Gen3 mid-block.
    applyStimulus(3'd4, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'b00);
    applyStimulus(3'd4, 32'h4000_0000, 4'h0, 1'b1, 1'b1, 1'b1, 2'b10);
    applyStimulus(3'd4, 32'h4000_0001, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    checkFrame("g4lock", 1, 0, 0, 2'b10, 1, 0, 0);
    applyStimulus(3'd3, 32'h4000_0002, 4'h0, 1'b1, 1'b1, 1'b0, 2'b00);
    checkFrame("genchg", 0, 0, 0, 2'b00, 0, 0, 0);
    applyStimulus(3'd3, 32'h3000_0000, 4'h0, 1'b1, 1'b1, 1'b1, 2'b10);
    checkFrame("g3relock", 1, 1, 0, 2'b10, 1, 0, 0);
    // RxValid drops mid-block.
    applyStimulus(3'd3, 32'h3000_0001, 4'h0, 1'b1, 1'b0, 1'b0, 2'b00);
    checkFrame("rxvalid0", 0, 0, 0, 2'b00, 0, 0, 0);
    // Re-lock then reset mid-block.
    applyStimulus(3'd3, 32'h3000_0002, 4'h0, 1'b1, 1'b1, 1'b1, 2'b01);
    checkFrame("g3lock2", 1, 1, 0, 2'b01, 1, 0, 0);
    reset = 1'b1;
    applyStimulus(3'd3, 32'h3000_0003, 4'hF, 1'b1, 1'b1, 1'b0, 2'b00);
    checkOutput("rst2.data", bus.descramblerDataIn, 32'h0);
    checkFrame("rst2", 0, 0, 0, 2'b00, 0, 0, 0);
    reset = 1'b0;

    // Unsupported generation forces everything to zero.
    applyStimulus(3'd6, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b1, 2'b10);
    checkOutput("g6.data", bus.descramblerDataIn, 32'h0);
    checkOutput("g6.k", 32'(bus.descramblerDataK), 32'h0);
    checkFrame("g6", 0, 0, 0, 2'b00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_rx_data.md
Name: pipe_rx_data

Overview:
Receive-side counterpart of the PIPE transmit data mux. Takes the PHY's PIPE RX data bus, registers it, and passes it to the descrambler. For Gen1/Gen2 it width-masks and forwards each beat. For Gen3 and above it tracks 128b/130b block framing: it locks on a valid sync header, counts beats per block, marks block start and end, and flags sync-header and alignment errors.

Parameters:
pipe_width_gen1, 8, PIPE RX data width in bits at Gen1
pipe_width_gen2, 8, PIPE RX data width in bits at Gen2
pipe_width_gen3, 16, PIPE RX data width in bits at Gen3; must divide 128
pipe_width_gen4, 32, PIPE RX data width in bits at Gen4; must divide 128
pipe_width_gen5, 32, PIPE RX data width in bits at Gen5; must divide 128

Ports:
pclk  input  1  PIPE clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
generation  input  3  link generation, 1..5; any other value is inactive
RxData  input  32  PIPE receive data; LSBs used per generation width
RxDataK  input  4  K-symbol flags, one per byte (Gen1/2 meaningful)
RxDataValid  input  1  PIPE beat qualifier (Gen3+ stall indication)
RxValid  input  1  PHY symbol lock / receive valid
RxStartBlock  input  1  first beat of a 130b block (Gen3+)
RxSyncHeader  input  2  sync header, sampled when RxStartBlock=1
descramblerDataIn  output  32  registered, width-masked data
descramblerDataK  output  4  registered, width-masked K flags
descramblerDataValid  output  1  beat valid to descrambler
descramblerSyncHeader  output  2  header of the current block
descramblerStartBlock  output  1  beat is first of block
descramblerBlockEnd  output  1  beat is last of block
syncHeaderError  output  1  one-cycle pulse: header 00 or 11
blockAlignError  output  1  one-cycle pulse: framing violation
blockLocked  output  1  block framing acquired (Gen3+)

Behaviour:
- Reset and all outputs: every output is registered, latency 1 pclk. Reset clears all outputs, the FSM (to SEEK) and beat_cnt. Reset mid-block drops lock with no error pulse.
- Width per generation: W = pipe_width_genN. Data bits [W-1:0] and K bits [W/8-1:0] pass through; upper bits are 0. BPB = 128/W (8 at Gen3, 4 at Gen4/5).
- Definitions: qual = RxValid & RxDataValid. gen_chg is true when generation differs from its value registered on the previous cycle.
- Unsupported generation (0, 6, 7): all outputs 0; FSM forced to SEEK.
- Gen1/2:
  - descramblerDataValid = qual.
  - descramblerSyncHeader, descramblerStartBlock, descramblerBlockEnd, both error outputs and blockLocked are 0.
  - Data and K update every cycle regardless of qual.
- Gen3+ FSM states: SEEK, LOCKED. beat_cnt is 3 bits, range 0..BPB-1.
- SEEK:
  - Outputs: valid=0, blockLocked=0, descramblerSyncHeader=0.
  - On qual & RxStartBlock with header 01 or 10: go to LOCKED; output the beat with valid=1 and StartBlock=1; latch the header; set beat_cnt=1.
  - On qual & RxStartBlock with header 00 or 11: syncHeaderError=1; stay in SEEK; no data output.
  - Any other cycle: stay in SEEK.
- LOCKED:
  - blockLocked=1.
  - !RxDataValid (with RxValid=1): stall; valid=0; beat_cnt holds; header holds.
  - qual, beat_cnt=0, RxStartBlock=1, header valid: output a start beat; latch the new header; set beat_cnt=1.
  - qual, beat_cnt=0, RxStartBlock=1, header invalid: syncHeaderError=1; go to SEEK; valid=0.
  - qual, beat_cnt=0, RxStartBlock=0: blockAlignError=1; go to SEEK; valid=0.
  - qual, beat_cnt≠0, RxStartBlock=1: blockAlignError=1; go to SEEK; valid=0. No re-lock on this same beat.
  - qual, beat_cnt≠0, RxStartBlock=0: output the beat with valid=1. When beat_cnt=BPB-1, assert BlockEnd=1 and wrap beat_cnt to 0; otherwise increment beat_cnt.
- RxValid=0 in any state: go to SEEK; clear beat_cnt; valid=0; no error pulse.
- gen_chg: go to SEEK; clear beat_cnt; no error pulse. The beat on the change cycle is not output at Gen3+.
- Precedence (high to low): reset > unsupported generation / gen_chg > RxValid=0 > FSM rules.
- Error pulses last exactly one cycle and are never asserted together with descramblerDataValid.

Test Plan:
- Gen1, RxData=0xAABBCC5C, RxDataK=4'hF, qual=1 -> next cycle descramblerDataIn=0x0000005C, DataK=4'h1, valid=1, blockLocked=0.
- Gen3 lock: StartBlock=1, header=2'b10, then 7 valid beats -> StartBlock=1 on beat 0, BlockEnd=1 only on beat 7, descramblerSyncHeader=2'b10 on all 8 beats, blockLocked=1 from beat 0.
- Gen4, RxDataValid low for 2 cycles after beat 1 of 4 -> valid=0 for those cycles, beat_cnt held, BlockEnd still on the 4th valid beat.
- Gen5 locked; StartBlock at beat_cnt=2 -> blockAlignError pulse, valid=0, blockLocked=0. A fresh StartBlock with header 01 on the next cycle re-locks.
- Gen3 SEEK, StartBlock with header 2'b11 -> syncHeaderError pulse, stays in SEEK. A missing StartBlock after BlockEnd while locked -> blockAlignError.
- Locked at Gen4; generation changes to 3 mid-block, then RxValid drops, then reset asserted -> SEEK, no error pulses, all outputs 0 the cycle after reset.
